gcd_queue_emu: RTL

Parametrised successor to the single-shot GCD peripheral in the GPIO emulator. It accepts operand pairs over the emulator's simple bus into a job FIFO and computes GCDs serially with a subtractive Euclid engine. Results go into a result FIFO that software reads back, and a wrapping completion counter drives `gpio_out`. It sits behind the same bus decode as the existing GPIO/GCD registers.

---
 rtl/gcd_queue_emu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/gcd_queue_emu.sv
// gcd_queue_emu: queued GCD peripheral on the emulator's simple bus.
// Operand pairs go into a job FIFO. A serial subtractive Euclid engine
// computes each GCD and pushes it into a result FIFO for software to read.
// A wrapping 32-bit completion counter drives gpio_out.
//
// Ports:
//   clk        - single clock; all state changes on the rising edge
//   n_reset    - asynchronous active-low reset
//   saddress   - bus address (16 bits)
//   srd, swr   - read/write strobes, asynchronous to clk
//   sdata_in   - bus write data (32 bits)
//   sdata_out  - registered bus read data (32 bits)
//   gpio_out   - completion counter (32 bits)
module gcd_queue_emu #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 4,
  parameter logic [15:0] ADDR_A    = 16'hF8,
  parameter logic [15:0] ADDR_B    = 16'hFC,
  parameter logic [15:0] ADDR_RES  = 16'hF4,
  parameter logic [15:0] ADDR_STAT = 16'hF0,
  parameter logic [15:0] ADDR_CNT  = 16'hEC
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic [31:0] gpio_out
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Strobe synchronizers: [1:0] are the 2-FF sync, [2] holds the previous
  // synchronized level for rising-edge detection.
  logic [2:0] rd_sync, wr_sync;
  logic       rd_edge, wr_edge;

  logic [WIDTH-1:0] a_stage;
  logic [WIDTH-1:0] job_a_mem [DEPTH];
  logic [WIDTH-1:0] job_b_mem [DEPTH];
  logic [WIDTH-1:0] res_mem   [DEPTH];
  logic [AW:0]      job_wp, job_rp, res_wp, res_rp;
  logic [AW:0]      job_cnt, res_cnt;
  logic             job_full, job_empty, res_full, res_empty;
  logic             job_push, job_pop, res_push, res_pop;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [31:0]      cnt;
  logic             ovf, udf;

  logic             wr_a, wr_b, wr_stat, rd_res;
  logic [31:0]      stat_word;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_sync <= '0;
      wr_sync <= '0;
    end else begin
      rd_sync <= {rd_sync[1:0], srd};
      wr_sync <= {wr_sync[1:0], swr};
    end
  end

  assign rd_edge = rd_sync[1] & ~rd_sync[2];
  assign wr_edge = wr_sync[1] & ~wr_sync[2];

  assign wr_a    = wr_edge && (saddress == ADDR_A);
  assign wr_b    = wr_edge && (saddress == ADDR_B);
  assign wr_stat = wr_edge && (saddress == ADDR_STAT);
  assign rd_res  = rd_edge && (saddress == ADDR_RES);

  assign job_cnt   = job_wp - job_rp;
  assign res_cnt   = res_wp - res_rp;
  assign job_full  = (job_cnt == FULL_CNT);
  assign job_empty = (job_cnt == '0);
  assign res_full  = (res_cnt == FULL_CNT);
  assign res_empty = (res_cnt == '0);

  assign job_push = wr_b && !job_full;
  assign job_pop  = (state == S_IDLE) && !job_empty;
  assign res_pop  = rd_res && !res_empty;
  // A bus pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign res_push = (state == S_DONE) && (!res_full || res_pop);

  always_comb begin
    stat_word        = '0;
    stat_word[0]     = (state != S_IDLE);
    stat_word[1]     = job_full;
    stat_word[2]     = res_empty;
    stat_word[3]     = ovf;
    stat_word[4]     = udf;
    stat_word[15:8]  = 8'(job_cnt);
    stat_word[23:16] = 8'(res_cnt);
  end

  // FIFO storage carries no reset; pointers alone define the contents.
  always_ff @(posedge clk) begin
    if (job_push) begin
      job_a_mem[job_wp[AW-1:0]] <= a_stage;
      job_b_mem[job_wp[AW-1:0]] <= sdata_in[WIDTH-1:0];
    end
    if (res_push) begin
      res_mem[res_wp[AW-1:0]] <= res_reg;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a_stage <= '0;
      job_wp  <= '0;
      job_rp  <= '0;
      res_wp  <= '0;
      res_rp  <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (wr_a)     a_stage <= sdata_in[WIDTH-1:0];
      if (job_push) job_wp  <= job_wp + 1'b1;
      if (job_pop)  job_rp  <= job_rp + 1'b1;
      if (res_push) res_wp  <= res_wp + 1'b1;
      if (res_pop)  res_rp  <= res_rp + 1'b1;
      if (wr_stat) begin
        if (sdata_in[3]) ovf <= 1'b0;
        if (sdata_in[4]) udf <= 1'b0;
      end
      // New error events take priority over a same-cycle clear.
      if (wr_b && job_full)    ovf <= 1'b1;
      if (rd_res && res_empty) udf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= S_IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!job_empty) begin
            a_reg <= job_a_mem[job_rp[AW-1:0]];
            b_reg <= job_b_mem[job_rp[AW-1:0]];
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (a_reg == '0 || b_reg == '0 || a_reg == b_reg) begin
            res_reg <= (a_reg == '0) ? b_reg : a_reg;
            state   <= S_DONE;
          end else if (a_reg > b_reg) begin
            a_reg <= a_reg - b_reg;
          end else begin
            b_reg <= b_reg - a_reg;
          end
        end
        S_DONE: begin
          if (res_push) begin
            cnt   <= cnt + 32'd1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sdata_out <= '0;
    end else if (rd_edge) begin
      case (saddress)
        ADDR_RES:  sdata_out <= res_empty ? '0 : 32'(res_mem[res_rp[AW-1:0]]);
        ADDR_STAT: sdata_out <= stat_word;
        ADDR_CNT:  sdata_out <= cnt;
        default:   sdata_out <= '0;
      endcase
    end
  end

  assign gpio_out = cnt;

endmodule
